// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// step counter width and the control FSM state encoding.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: ripple subtract of the divisor from the shifted
// partial remainder, with an extra top bit so the borrow is exact.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic             borrow,
  output logic [WIDTH-1:0] next_rem
);

  logic             subtract_signal;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] trial;

  assign subtract_signal = 1'b1;

  always_comb begin
    b_eff    = divisor ^ {WIDTH{subtract_signal}};
    carry    = '0;
    carry[0] = subtract_signal;
    trial    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      trial[i]   = shifted[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (shifted[i] & b_eff[i]) | (carry[i] & (shifted[i] ^ b_eff[i]));
    end
    // Extension bit: the zero-extended divisor contributes an inverted 0 (= 1).
    borrow = ~((shifted[WIDTH] & subtract_signal) |
               (carry[WIDTH] & (shifted[WIDTH] ^ subtract_signal)));
    // The kept remainder is always below the divisor, so it fits in WIDTH bits.
    next_rem = borrow ? shifted[WIDTH-1:0] : trial;
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential divider: one restoring step per cycle, WIDTH cycles per
// result, valid/ready handshakes on operand and result sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on valid, and a producer holds its data while
  // valid is 1 and ready is 0.

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] qreg;
  logic [CW-1:0]    cnt;
  logic             zero_div;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic             borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] q_next;
  logic             last_step;

  assign shifted   = {1'b0, rem_q, qreg[WIDTH-1]};
  assign q_next    = {qreg[WIDTH-2:0], ~borrow};
  assign last_step = (cnt == CW'(WIDTH - 1));

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .shifted  (shifted),
    .divisor  (divisor_q),
    .borrow   (borrow),
    .next_rem (next_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (zero_div || last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor_q   <= '0;
      rem_q       <= '0;
      qreg        <= '0;
      cnt         <= '0;
      zero_div    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          divisor_q <= divisor;
          rem_q     <= '0;
          qreg      <= dividend;
          cnt       <= '0;
          zero_div  <= (divisor == '0);
          if (divisor != '0) dbz_q <= 1'b0;
        end
        RUN: if (zero_div) begin
          // Zero divisor spends its single busy cycle here without stepping.
          quotient_q  <= '1;
          remainder_q <= qreg;
          dbz_q       <= 1'b1;
        end else begin
          rem_q <= next_rem;
          qreg  <= q_next;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            quotient_q  <= q_next;
            remainder_q <= next_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotient/remainder vectors,
// latency, stall, abort-by-reset and input-noise scenarios.
module tb_seq_divider;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns just after the accepting rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", W'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
  endtask

  task automatic collect(input int lat_exp, input bit noisy, input int stall);
    int cyc = 0;
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid || cyc > 200) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    check("latency", W'(cyc), W'(lat_exp));
    check("quotient", quotient, e[2*W-1:W]);
    check("remainder", remainder, e[W-1:0]);
    check("div_by_zero", W'(div_by_zero), W'(e[2*W]));
    check("in_ready_done", W'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", W'(out_valid), 1);
      check("stall_quotient", quotient, e[2*W-1:W]);
      check("stall_remainder", remainder, e[W-1:0]);
      check("stall_in_ready", W'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", W'(out_valid), 0);
    check("drain_in_ready", W'(in_ready), 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input bit z,
                        input int lat, input bit noisy, input int stall);
    exp_q.push_back({z, q, r});
    send(a, b);
    collect(lat, noisy, stall);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    do_reset();
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", W'(div_by_zero), 0);

    run_op(100, 7, 14, 2, 1'b0, 64, 1'b0, 0);
    run_op(ONES, 1, ONES, 0, 1'b0, 64, 1'b0, 0);
    run_op(ONES, ONES, 1, 0, 1'b0, 64, 1'b0, 0);
    run_op(0, 1, 0, 0, 1'b0, 64, 1'b0, 0);
    run_op(5, 0, ONES, 5, 1'b1, 1, 1'b0, 0);
    run_op(9, 3, 3, 0, 1'b0, 64, 1'b0, 0);
    run_op(100, 7, 14, 2, 1'b0, 64, 1'b0, 10);

    // Abort a division partway through with reset.
    send(1000, 3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", W'(in_ready), 1);
    check("abort_out_valid", W'(out_valid), 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", W'(seen), 0);
    run_op(3, 5, 0, 3, 1'b0, 64, 1'b0, 0);

    run_op(1000000, 13, 76923, 1, 1'b0, 64, 1'b1, 0);
    run_op(64'd12345678901, 1000, 12345678, 901, 1'b0, 64, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
